// File: rtl/serial_chunk_adder_pkg.sv
// Shared types for the serial chunk adder: FSM state encoding and index-width helper.
// Optional subtract/overflow feature is enabled with SERIAL_CHUNK_ADDER_SUB_EN.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Chunk index counter width; a single-chunk adder still gets one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_chunk_adder_if.sv
// Operand/result handshake bundle for serial_chunk_adder.
// sub and ovf exist only when SERIAL_CHUNK_ADDER_SUB_EN is defined.
interface serial_chunk_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             busy;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  logic             sub;
  logic             ovf;

  modport master (output in_valid, A, B, Cin, sub, out_ready,
                  input  in_ready, out_valid, S, Cout, busy, ovf);
  modport slave  (input  in_valid, A, B, Cin, sub, out_ready,
                  output in_ready, out_valid, S, Cout, busy, ovf);
`else
  modport master (output in_valid, A, B, Cin, out_ready,
                  input  in_ready, out_valid, S, Cout, busy);
  modport slave  (input  in_valid, A, B, Cin, out_ready,
                  output in_ready, out_valid, S, Cout, busy);
`endif
endinterface

// File: rtl/serial_chunk_adder_chunk.sv
// Combinational CHUNK-bit ripple slice built from full-adder cells.
// c_msb_in exposes the carry into the top bit for signed-overflow detection.
module adder_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign cout     = c_s[CHUNK];
  assign c_msb_in = c_s[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle WIDTH-bit adder processing CHUNK bits per clock through one shared slice.
// Define SERIAL_CHUNK_ADDER_SUB_EN to add the sub input and the ovf output.
module serial_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 2
) (
  input logic                clk,
  input logic                rst_n,
  serial_chunk_adder_if.slave bus
);

  localparam int            N    = WIDTH / CHUNK;
  localparam int            IW   = idx_width(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;

  logic [CHUNK-1:0]       slice_s_s;
  logic                   slice_cout_s, slice_c_msb_s;
  logic [WIDTH+CHUNK-1:0] s_shift_s;

  adder_chunk #(.CHUNK(CHUNK)) u_slice (
    .a        (a_q[CHUNK-1:0]),
    .b        (b_q[CHUNK-1:0]),
    .cin      (carry_q),
    .s        (slice_s_s),
    .cout     (slice_cout_s),
    .c_msb_in (slice_c_msb_s)
  );

  // Sum bits enter at the MSB end; the concatenation keeps CHUNK==WIDTH legal.
  assign s_shift_s = {slice_s_s, s_q};

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  logic ovf_q, ovf_d;
  assign bus.ovf = ovf_q;
`else
  logic unused_c_msb_s;
  assign unused_c_msb_s = slice_c_msb_s;
`endif

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d   = bus.A;
          idx_d = '0;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
          if (bus.sub) begin
            b_d     = ~bus.B;
            carry_d = 1'b1;
          end else begin
            b_d     = bus.B;
            carry_d = bus.Cin;
          end
`else
          b_d     = bus.B;
          carry_d = bus.Cin;
`endif
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        s_d     = s_shift_s[WIDTH+CHUNK-1:CHUNK];
        carry_d = slice_cout_s;
        if (idx_q == LAST) begin
          cout_d  = slice_cout_s;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
          ovf_d   = slice_c_msb_s ^ slice_cout_s;
`endif
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == RUN);
  end

  // State, datapath and output flops; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Scoreboard bench for serial_chunk_adder (16/2 main instance plus an 8/8 single-chunk instance).
// Exercises sub/ovf as well when SERIAL_CHUNK_ADDER_SUB_EN is defined.
module tb_serial_chunk_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb_q[$];

  serial_chunk_adder_if #(.WIDTH(16)) bif ();
  serial_chunk_adder_if #(.WIDTH(8))  bif8 ();

  serial_chunk_adder #(.WIDTH(16), .CHUNK(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif8.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Pops the oldest expected result on every output handshake.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bif.out_valid && bif.out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sum", {16'd0, bif.S}, {16'd0, e.s});
          chk("cout", {31'd0, bif.Cout}, {31'd0, e.c});
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
          chk("ovf", {31'd0, bif.ovf}, {31'd0, e.o});
`endif
        end
      end
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sb, input logic push,
                      input logic [15:0] es, input logic ec, input logic eo);
    exp_t e;
    int w = 0;
    while (!bif.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bif.in_ready) chk("accept_timeout", 32'd1, 32'd0);
    bif.in_valid = 1'b1;
    bif.A = a;
    bif.B = b;
    bif.Cin = cin;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    bif.sub = sb;
`endif
    if (sb === 1'bx) chk("sub_flag_known", 32'd1, 32'd0);
    if (push) begin
      e.s = es; e.c = ec; e.o = eo;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid; reports edges waited and cycles with busy high.
  task automatic wait_out(output int cyc, output int bz);
    cyc = 0;
    bz  = 0;
    while (!bif.out_valid && cyc < 100) begin
      if (bif.busy) bz++;
      @(posedge clk); #1;
      cyc++;
    end
    if (!bif.out_valid) chk("result_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int cyc, bz;
    bif.in_valid = 1'b0; bif.A = '0; bif.B = '0; bif.Cin = 1'b0; bif.out_ready = 1'b1;
    bif8.in_valid = 1'b0; bif8.A = '0; bif8.B = '0; bif8.Cin = 1'b0; bif8.out_ready = 1'b1;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    bif.sub = 1'b0;
    bif8.sub = 1'b0;
`endif
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bif.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, bif.busy}, 32'd0);
    chk("rst_s", {16'd0, bif.S}, 32'd0);
    chk("rst_cout", {31'd0, bif.Cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add with latency and busy-length checks
    send(16'h1234, 16'h0FED, 1'b0, 1'b0, 1'b1, 16'h2221, 1'b0, 1'b0);
    wait_out(cyc, bz);
    chk("latency", cyc, 32'd8);
    chk("busy_cycles", bz, 32'd8);
    @(posedge clk); #1;
    chk("done_to_idle_out_valid", {31'd0, bif.out_valid}, 32'd0);

    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    wait_out(cyc, bz);
    @(posedge clk); #1;
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    wait_out(cyc, bz);
    @(posedge clk); #1;
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    wait_out(cyc, bz);
    @(posedge clk); #1;

    // Backpressure: result must hold while out_ready is low
    bif.out_ready = 1'b0;
    send(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    wait_out(cyc, bz);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", {31'd0, bif.out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, bif.in_ready}, 32'd0);
      chk("bp_s", {16'd0, bif.S}, 32'h0000FFFF);
      chk("bp_cout", {31'd0, bif.Cout}, 32'd0);
    end
    bif.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", {31'd0, bif.out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, bif.in_ready}, 32'd1);
    send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    wait_out(cyc, bz);
    @(posedge clk); #1;

    // New operands offered during RUN must be ignored
    send(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    bif.in_valid = 1'b1; bif.A = 16'h7777; bif.B = 16'h1111; bif.Cin = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("run_in_ready", {31'd0, bif.in_ready}, 32'd0);
    end
    bif.in_valid = 1'b0;
    wait_out(cyc, bz);
    chk("run_ignore_latency", cyc, 32'd3);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", {31'd0, bif.in_ready}, 32'd1);
    chk("async_rst_busy", {31'd0, bif.busy}, 32'd0);
    chk("async_rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
    chk("async_rst_s", {16'd0, bif.S}, 32'd0);
    chk("async_rst_cout", {31'd0, bif.Cout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'd5, 16'd7, 1'b0, 1'b0, 1'b1, 16'd12, 1'b0, 1'b0);
    wait_out(cyc, bz);
    chk("post_rst_latency", cyc, 32'd8);
    @(posedge clk); #1;

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    wait_out(cyc, bz);
    @(posedge clk); #1;
    send(16'h0003, 16'h0005, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    wait_out(cyc, bz);
    @(posedge clk); #1;
`endif

    // Single-chunk instance: RUN lasts one cycle
    bif8.in_valid = 1'b1; bif8.A = 8'hF0; bif8.B = 8'h1F; bif8.Cin = 1'b1;
    @(posedge clk); #1;
    bif8.in_valid = 1'b0;
    chk("w8_busy", {31'd0, bif8.busy}, 32'd1);
    @(posedge clk); #1;
    chk("w8_out_valid", {31'd0, bif8.out_valid}, 32'd1);
    chk("w8_s", {24'd0, bif8.S}, 32'h10);
    chk("w8_cout", {31'd0, bif8.Cout}, 32'd1);
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    chk("w8_ovf", {31'd0, bif8.ovf}, 32'd0);
`endif
    @(posedge clk); #1;
    chk("w8_out_valid_drop", {31'd0, bif8.out_valid}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
